// File: rtl/gemm_pkg.sv
// Shared encodings for the GEMM instruction sequencer: opcodes, buffer ids,
// array control states, instruction field positions and the sequencer FSM states.
package gemm_pkg;

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_HALT     = 4'd1;
  localparam logic [3:0] OP_LD       = 4'd2;
  localparam logic [3:0] OP_ST       = 4'd3;
  localparam logic [3:0] OP_GEMM     = 4'd4;
  localparam logic [3:0] OP_DRAINSYS = 4'd5;

  localparam logic [1:0] BUF_TOP  = 2'd0;
  localparam logic [1:0] BUF_LEFT = 2'd1;
  localparam logic [1:0] BUF_DOWN = 2'd2;
  localparam logic [1:0] BUF_RSVD = 2'd3;

  localparam logic [3:0] CTRL_IDLE   = 4'd0;
  localparam logic [3:0] CTRL_WARMUP = 4'd1;
  localparam logic [3:0] CTRL_STEADY = 4'd2;
  localparam logic [3:0] CTRL_DRAIN  = 4'd3;

  localparam int MEM_LOC_IDX = 0;
  localparam int BUF_ID_IDX  = 26;
  localparam int OPCODE_IDX  = 28;

  typedef enum logic [2:0] {S_HALT, S_FETCH, S_DECODE, S_EXEC, S_DONE} state_e;

endpackage

// File: rtl/gemm_inst_sequencer_inst_mem.sv
// Instruction store: synchronous 1R1W RAM, one-cycle registered read.
// Out-of-range addresses are ignored on write and leave the read register unchanged.
module inst_mem #(
  parameter int DEPTH = 2048,
  parameter int AW    = 12,
  parameter int W     = 32
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  localparam int IW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i && int'(wr_addr_i) < DEPTH) mem_q[wr_addr_i[IW-1:0]] <= wr_data_i;
    if (rd_en_i && int'(rd_addr_i) < DEPTH) rd_data_q <= mem_q[rd_addr_i[IW-1:0]];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gemm_inst_sequencer.sv
// Fetch/decode/execute controller for the 4x4 systolic GEMM block: LD, ST, GEMM, DRAINSYS.
// Strobes, addresses and control state are registered; write data follows the read data it forwards.
module gemm_inst_sequencer
  import gemm_pkg::*;
#(
  parameter int INST_WIDTH            = 32,
  parameter int OPCODE_WIDTH          = 4,
  parameter int BUF_ID_WIDTH          = 2,
  parameter int MEM_LOC_WIDTH         = 26,
  parameter int INST_MEMORY_SIZE      = 2048,
  parameter int LOG2_INST_MEMORY_SIZE = 12,
  parameter int NUM_ROW               = 4,
  parameter int NUM_COL               = 4,
  parameter int DATA_WIDTH            = 16,
  parameter int ACCU_DATA_WIDTH       = 16,
  parameter int SRAM_BANK_DEPTH       = 4,
  parameter int LOG2_SRAM_BANK_DEPTH  = 4,
  parameter int CTRL_WIDTH            = 4,
  parameter int RD_LATENCY            = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 inst_wr_en,
  input  logic [LOG2_INST_MEMORY_SIZE-1:0]     inst_wr_addr,
  input  logic [INST_WIDTH-1:0]                inst_wr_data,
  input  logic                                 start,
  output logic                                 busy,
  output logic [OPCODE_WIDTH-1:0]              opcode,
  output logic [BUF_ID_WIDTH-1:0]              buf_id,
  output logic [MEM_LOC_WIDTH-1:0]             mem_loc,
  output logic                                 mem_rd_en,
  output logic                                 mem_wr_en,
  output logic [MEM_LOC_WIDTH-1:0]             mem_addr,
  output logic [NUM_COL*ACCU_DATA_WIDTH-1:0]   mem_wr_data,
  input  logic [NUM_COL*DATA_WIDTH-1:0]        mem_rd_data,
  output logic                                 i_top_wr_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_top_wr_addr,
  output logic [NUM_COL*DATA_WIDTH-1:0]        i_top_wr_data,
  output logic                                 i_left_wr_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_left_wr_addr,
  output logic [NUM_ROW*DATA_WIDTH-1:0]        i_left_wr_data,
  output logic                                 i_down_rd_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_down_rd_addr,
  input  logic [NUM_COL*ACCU_DATA_WIDTH-1:0]   o_down_rd_data,
  output logic [CTRL_WIDTH-1:0]                i_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_top_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_down_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_down_sram_rd_end_addr
);

  localparam int CNT_W = 5;
  localparam int LW    = NUM_ROW*DATA_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(SRAM_BANK_DEPTH);
  localparam logic [CNT_W-1:0] RDL_C     = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] LD_LEN    = CNT_W'(SRAM_BANK_DEPTH + 1);
  localparam logic [CNT_W-1:0] ST_LEN    = CNT_W'(SRAM_BANK_DEPTH + RD_LATENCY);
  localparam logic [CNT_W-1:0] GEMM_LEN  = CNT_W'(1 + SRAM_BANK_DEPTH + NUM_ROW + NUM_COL - 2);
  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(NUM_ROW + NUM_COL);
  localparam logic [LOG2_SRAM_BANK_DEPTH-1:0] END_ADDR = LOG2_SRAM_BANK_DEPTH'(SRAM_BANK_DEPTH - 1);
  localparam logic [LOG2_INST_MEMORY_SIZE-1:0] LAST_PC = LOG2_INST_MEMORY_SIZE'(INST_MEMORY_SIZE - 1);

  state_e                             state_q;
  logic [LOG2_INST_MEMORY_SIZE-1:0]   pc_q;
  logic [CNT_W-1:0]                   cnt_q;
  logic [CNT_W-1:0]                   op_len_d;
  logic                               busy_q;
  logic [OPCODE_WIDTH-1:0]            opcode_q;
  logic [BUF_ID_WIDTH-1:0]            buf_id_q;
  logic [MEM_LOC_WIDTH-1:0]           mem_loc_q;
  logic                               mem_rd_en_q, mem_wr_en_q;
  logic [MEM_LOC_WIDTH-1:0]           mem_addr_q;
  logic                               top_wr_en_q, left_wr_en_q, down_rd_en_q;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]    top_wr_addr_q, left_wr_addr_q, down_rd_addr_q;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]    rd_start_q, rd_end_q;
  logic [CTRL_WIDTH-1:0]              ctrl_q;
  logic [INST_WIDTH-1:0]              imem_rd_data;

  inst_mem #(
    .DEPTH (INST_MEMORY_SIZE),
    .AW    (LOG2_INST_MEMORY_SIZE),
    .W     (INST_WIDTH)
  ) u_inst_mem (
    .clk_i     (clk),
    .wr_en_i   (inst_wr_en && state_q == S_HALT),
    .wr_addr_i (inst_wr_addr),
    .wr_data_i (inst_wr_data),
    .rd_en_i   (state_q == S_FETCH),
    .rd_addr_i (pc_q),
    .rd_data_o (imem_rd_data)
  );

  // Length of the EXEC phase in cycles; LD/ST to a bank they cannot address collapse to a NOP.
  always_comb begin
    op_len_d = '0;
    case (opcode_q)
      OP_LD:       if (buf_id_q != BUF_DOWN && buf_id_q != BUF_RSVD) op_len_d = LD_LEN;
      OP_ST:       if (buf_id_q == BUF_DOWN) op_len_d = ST_LEN;
      OP_GEMM:     op_len_d = GEMM_LEN;
      OP_DRAINSYS: op_len_d = DRAIN_LEN;
      OP_NOP, OP_HALT: op_len_d = '0;
      default:     op_len_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_HALT;
      pc_q           <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      opcode_q       <= '0;
      buf_id_q       <= '0;
      mem_loc_q      <= '0;
      mem_rd_en_q    <= 1'b0;
      mem_wr_en_q    <= 1'b0;
      mem_addr_q     <= '0;
      top_wr_en_q    <= 1'b0;
      top_wr_addr_q  <= '0;
      left_wr_en_q   <= 1'b0;
      left_wr_addr_q <= '0;
      down_rd_en_q   <= 1'b0;
      down_rd_addr_q <= '0;
      rd_start_q     <= '0;
      rd_end_q       <= '0;
      ctrl_q         <= '0;
    end else begin
      mem_rd_en_q    <= 1'b0;
      mem_wr_en_q    <= 1'b0;
      mem_addr_q     <= '0;
      top_wr_en_q    <= 1'b0;
      top_wr_addr_q  <= '0;
      left_wr_en_q   <= 1'b0;
      left_wr_addr_q <= '0;
      down_rd_en_q   <= 1'b0;
      down_rd_addr_q <= '0;
      case (state_q)
        S_HALT: if (start) begin
          pc_q    <= '0;
          busy_q  <= 1'b1;
          state_q <= S_FETCH;
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          opcode_q  <= imem_rd_data[OPCODE_IDX +: OPCODE_WIDTH];
          buf_id_q  <= imem_rd_data[BUF_ID_IDX +: BUF_ID_WIDTH];
          mem_loc_q <= imem_rd_data[MEM_LOC_IDX +: MEM_LOC_WIDTH];
          cnt_q     <= '0;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == op_len_d) begin
            ctrl_q  <= CTRL_WIDTH'(CTRL_IDLE);
            state_q <= S_DONE;
          end else begin
            case (opcode_q)
              OP_LD: begin
                if (cnt_q < DEPTH_C) begin
                  mem_rd_en_q <= 1'b1;
                  mem_addr_q  <= mem_loc_q + MEM_LOC_WIDTH'(cnt_q);
                end
                // Bank write trails its main-memory read by one cycle.
                if (cnt_q != '0) begin
                  if (buf_id_q == BUF_TOP) begin
                    top_wr_en_q   <= 1'b1;
                    top_wr_addr_q <= LOG2_SRAM_BANK_DEPTH'(cnt_q - 1'b1);
                  end else begin
                    left_wr_en_q   <= 1'b1;
                    left_wr_addr_q <= LOG2_SRAM_BANK_DEPTH'(cnt_q - 1'b1);
                  end
                end
              end
              OP_ST: begin
                if (cnt_q < DEPTH_C) begin
                  down_rd_en_q   <= 1'b1;
                  down_rd_addr_q <= LOG2_SRAM_BANK_DEPTH'(cnt_q);
                end
                if (cnt_q >= RDL_C) begin
                  mem_wr_en_q <= 1'b1;
                  mem_addr_q  <= mem_loc_q + MEM_LOC_WIDTH'(cnt_q - RDL_C);
                end
              end
              OP_GEMM: begin
                if (cnt_q == '0) begin
                  ctrl_q     <= CTRL_WIDTH'(CTRL_WARMUP);
                  rd_start_q <= '0;
                  rd_end_q   <= END_ADDR;
                end else begin
                  ctrl_q <= CTRL_WIDTH'(CTRL_STEADY);
                end
              end
              default: ctrl_q <= CTRL_WIDTH'(CTRL_DRAIN);
            endcase
          end
        end
        S_DONE: begin
          if (opcode_q == OP_HALT) begin
            busy_q  <= 1'b0;
            state_q <= S_HALT;
          end else begin
            pc_q    <= (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign busy        = busy_q;
  assign opcode      = opcode_q;
  assign buf_id      = buf_id_q;
  assign mem_loc     = mem_loc_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign i_top_wr_en    = top_wr_en_q;
  assign i_top_wr_addr  = top_wr_addr_q;
  assign i_left_wr_en   = left_wr_en_q;
  assign i_left_wr_addr = left_wr_addr_q;
  assign i_down_rd_en   = down_rd_en_q;
  assign i_down_rd_addr = down_rd_addr_q;
  assign i_ctrl_state   = ctrl_q;

  // Read data arrives in the same cycle as the registered write strobe, so it is forwarded, gated by that strobe.
  assign i_top_wr_data  = top_wr_en_q  ? mem_rd_data : '0;
  assign i_left_wr_data = left_wr_en_q ? LW'(mem_rd_data) : '0;
  assign mem_wr_data    = mem_wr_en_q  ? o_down_rd_data : '0;

  assign i_top_sram_rd_start_addr  = rd_start_q;
  assign i_left_sram_rd_start_addr = rd_start_q;
  assign i_down_sram_rd_start_addr = rd_start_q;
  assign i_top_sram_rd_end_addr    = rd_end_q;
  assign i_left_sram_rd_end_addr   = rd_end_q;
  assign i_down_sram_rd_end_addr   = rd_end_q;

endmodule

// File: tb/tb_gemm_inst_sequencer.sv
// Directed bench for gemm_inst_sequencer with behavioural main memory and down-SRAM models.
module tb_gemm_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_wr_en = 1'b0;
  logic [11:0] inst_wr_addr = '0;
  logic [31:0] inst_wr_data = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [3:0]  opcode;
  logic [1:0]  buf_id;
  logic [25:0] mem_loc;
  logic        mem_rd_en, mem_wr_en;
  logic [25:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic [63:0] mem_rd_data = '0;
  logic        i_top_wr_en, i_left_wr_en, i_down_rd_en;
  logic [3:0]  i_top_wr_addr, i_left_wr_addr, i_down_rd_addr;
  logic [63:0] i_top_wr_data, i_left_wr_data;
  logic [63:0] o_down_rd_data = '0;
  logic [3:0]  i_ctrl_state;
  logic [3:0]  ts_a, te_a, ls_a, le_a, ds_a, de_a;

  always #5 clk = ~clk;

  gemm_inst_sequencer dut (
    .clk(clk), .rst(rst), .inst_wr_en(inst_wr_en), .inst_wr_addr(inst_wr_addr),
    .inst_wr_data(inst_wr_data), .start(start), .busy(busy), .opcode(opcode),
    .buf_id(buf_id), .mem_loc(mem_loc), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .i_top_wr_en(i_top_wr_en), .i_top_wr_addr(i_top_wr_addr), .i_top_wr_data(i_top_wr_data),
    .i_left_wr_en(i_left_wr_en), .i_left_wr_addr(i_left_wr_addr), .i_left_wr_data(i_left_wr_data),
    .i_down_rd_en(i_down_rd_en), .i_down_rd_addr(i_down_rd_addr), .o_down_rd_data(o_down_rd_data),
    .i_ctrl_state(i_ctrl_state),
    .i_top_sram_rd_start_addr(ts_a), .i_top_sram_rd_end_addr(te_a),
    .i_left_sram_rd_start_addr(ls_a), .i_left_sram_rd_end_addr(le_a),
    .i_down_sram_rd_start_addr(ds_a), .i_down_sram_rd_end_addr(de_a)
  );

  // Main memory answers one cycle after mem_rd_en; down SRAM answers two cycles after i_down_rd_en.
  logic [63:0] mainmem [256];
  logic [63:0] downmem [4];
  logic        dsr_en = 1'b0;
  logic [3:0]  dsr_addr = '0;
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mainmem[mem_addr[7:0]];
    dsr_en   <= i_down_rd_en;
    dsr_addr <= i_down_rd_addr;
    if (dsr_en) o_down_rd_data <= downmem[dsr_addr[1:0]];
  end

  int checks = 0;
  int errors = 0;

  int n_mrd, n_mwr, n_top, n_left, n_drd, n_strobe;
  int n_warm, n_steady, n_drain, warm_cyc, first_steady, last_steady, first_drain, last_drain;
  int busy_cycles;
  logic timed_out;
  logic [3:0] exec_op;
  logic [25:0] mrd_addr [8];
  logic [25:0] mwr_addr [8];
  logic [63:0] mwr_dat  [8];
  logic [3:0]  top_addr [8];
  logic [63:0] top_dat  [8];
  logic [3:0]  left_addr[8];
  logic [63:0] left_dat [8];
  logic [3:0]  drd_addr [8];
  int mrd_cyc[8], mwr_cyc[8], top_cyc[8], drd_cyc[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [1:0] b, input logic [25:0] loc);
    return {op, b, loc};
  endfunction

  function automatic logic any_out();
    return busy | (|opcode) | (|buf_id) | (|mem_loc) | mem_rd_en | mem_wr_en | (|mem_addr) |
           (|mem_wr_data) | i_top_wr_en | (|i_top_wr_addr) | (|i_top_wr_data) | i_left_wr_en |
           (|i_left_wr_addr) | (|i_left_wr_data) | i_down_rd_en | (|i_down_rd_addr) |
           (|i_ctrl_state) | (|ts_a) | (|te_a) | (|ls_a) | (|le_a) | (|ds_a) | (|de_a);
  endfunction

  task automatic load(input int a, input logic [31:0] d);
    inst_wr_en   = 1'b1;
    inst_wr_addr = a[11:0];
    inst_wr_data = d;
    tick();
    inst_wr_en = 1'b0;
  endtask

  // Pulses start, then records every strobe until busy falls; at cycle poke_at it pulses start
  // and an instruction write to address 0 together, both of which should be ignored.
  task automatic trace(input int budget, input int poke_at);
    int cyc;
    n_mrd = 0; n_mwr = 0; n_top = 0; n_left = 0; n_drd = 0; n_strobe = 0;
    n_warm = 0; n_steady = 0; n_drain = 0; warm_cyc = -1;
    first_steady = -1; last_steady = -1; first_drain = -1; last_drain = -1;
    exec_op = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (busy && cyc < budget) begin
      if (mem_rd_en && n_mrd == 0) exec_op = opcode;
      if (mem_rd_en && n_mrd < 8) begin mrd_addr[n_mrd] = mem_addr; mrd_cyc[n_mrd] = cyc; n_mrd++; end
      if (mem_wr_en && n_mwr < 8) begin
        mwr_addr[n_mwr] = mem_addr; mwr_dat[n_mwr] = mem_wr_data; mwr_cyc[n_mwr] = cyc; n_mwr++;
      end
      if (i_top_wr_en && n_top < 8) begin
        top_addr[n_top] = i_top_wr_addr; top_dat[n_top] = i_top_wr_data; top_cyc[n_top] = cyc; n_top++;
      end
      if (i_left_wr_en && n_left < 8) begin
        left_addr[n_left] = i_left_wr_addr; left_dat[n_left] = i_left_wr_data; n_left++;
      end
      if (i_down_rd_en && n_drd < 8) begin drd_addr[n_drd] = i_down_rd_addr; drd_cyc[n_drd] = cyc; n_drd++; end
      if (mem_rd_en || mem_wr_en || i_top_wr_en || i_left_wr_en || i_down_rd_en || i_ctrl_state != 4'd0)
        n_strobe++;
      case (i_ctrl_state)
        4'd1: begin n_warm++; warm_cyc = cyc; end
        4'd2: begin if (first_steady < 0) first_steady = cyc; last_steady = cyc; n_steady++; end
        4'd3: begin if (first_drain < 0) first_drain = cyc; last_drain = cyc; n_drain++; end
        default: ;
      endcase
      start        = (cyc == poke_at);
      inst_wr_en   = (cyc == poke_at);
      inst_wr_addr = '0;
      inst_wr_data = enc(4'd4, 2'd0, 26'd0);
      tick();
      start      = 1'b0;
      inst_wr_en = 1'b0;
      cyc++;
    end
    timed_out   = busy;
    busy_cycles = cyc - 1;
  endtask

  task automatic test_reset();
    logic bad;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (any_out() !== 1'b0) begin errors++; $display("FAIL reset_outputs got %b want 0", any_out()); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    bad = 1'b0;
    repeat (5) begin tick(); if (any_out() !== 1'b0) bad = 1'b1; end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b want 0", bad); end
  endtask

  task automatic test_ld_top();
    for (int i = 0; i < 4; i++) mainmem[8'h10 + i] = 64'hA0A0_1111_2222_3300 + 64'(i);
    load(0, enc(4'd2, 2'd0, 26'h10));
    load(1, enc(4'd1, 2'd0, 26'd0));
    trace(60, 0);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL ld_top_timeout busy %b want 0", timed_out); end
    checks++;
    if (exec_op !== 4'd2) begin errors++; $display("FAIL ld_top_opcode got %0d want 2", exec_op); end
    checks++;
    if (n_mrd != 4 || n_top != 4) begin
      errors++; $display("FAIL ld_top_counts rd %0d wr %0d want 4 4", n_mrd, n_top);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (mrd_addr[i] !== 26'(32'h10 + i) || top_addr[i] !== 4'(i) ||
            top_dat[i] !== 64'hA0A0_1111_2222_3300 + 64'(i) || top_cyc[i] != mrd_cyc[i] + 1) begin
          errors++;
          $display("FAIL ld_top_row%0d rd %h wr_addr %0d data %h dcyc %0d want %h %0d %h 1", i,
                   mrd_addr[i], top_addr[i], top_dat[i], top_cyc[i] - mrd_cyc[i],
                   26'(32'h10 + i), i, 64'hA0A0_1111_2222_3300 + 64'(i));
        end
      end
    end
    checks++;
    if (n_left != 0) begin errors++; $display("FAIL ld_top_left_quiet got %0d want 0", n_left); end
  endtask

  task automatic test_addr_wrap();
    load(0, enc(4'd2, 2'd0, 26'h3FF_FFFE));
    load(1, enc(4'd1, 2'd0, 26'd0));
    trace(60, 0);
    checks++;
    if (n_mrd != 4 || mrd_addr[0] !== 26'h3FF_FFFE || mrd_addr[1] !== 26'h3FF_FFFF ||
        mrd_addr[2] !== 26'h0 || mrd_addr[3] !== 26'h1) begin
      errors++;
      $display("FAIL addr_wrap n %0d got %h %h %h %h want 3fffffe 3ffffff 0 1", n_mrd,
               mrd_addr[0], mrd_addr[1], mrd_addr[2], mrd_addr[3]);
    end
  endtask

  task automatic test_ld_left_gemm();
    for (int i = 0; i < 4; i++) mainmem[8'h20 + i] = 64'hBEEF_0000_0000_0050 + 64'(i);
    load(0, enc(4'd2, 2'd1, 26'h20));
    load(1, enc(4'd4, 2'd0, 26'd0));
    load(2, enc(4'd1, 2'd0, 26'd0));
    trace(100, 0);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL gemm_timeout busy %b want 0", timed_out); end
    checks++;
    if (n_left != 4 || n_top != 0 || left_addr[3] !== 4'd3 || left_dat[3] !== 64'hBEEF_0000_0000_0053) begin
      errors++;
      $display("FAIL ld_left left %0d top %0d addr3 %0d data3 %h want 4 0 3 beef000000000053",
               n_left, n_top, left_addr[3], left_dat[3]);
    end
    checks++;
    if (n_warm != 1) begin errors++; $display("FAIL gemm_warmup_len got %0d want 1", n_warm); end
    checks++;
    if (n_steady != 10 || first_steady != warm_cyc + 1 || last_steady != first_steady + 9) begin
      errors++;
      $display("FAIL gemm_steady n %0d span %0d gap %0d want 10 10 1", n_steady,
               last_steady - first_steady + 1, first_steady - warm_cyc);
    end
    checks++;
    if (i_ctrl_state !== 4'd0) begin errors++; $display("FAIL gemm_idle_after got %0d want 0", i_ctrl_state); end
    checks++;
    if ({te_a, le_a, de_a} !== {3{4'd3}} || {ts_a, ls_a, ds_a} !== 12'd0) begin
      errors++; $display("FAIL gemm_windows end %h start %h want 333 000", {te_a, le_a, de_a}, {ts_a, ls_a, ds_a});
    end
  endtask

  task automatic test_drain();
    load(0, enc(4'd5, 2'd0, 26'd0));
    load(1, enc(4'd1, 2'd0, 26'd0));
    trace(60, 0);
    checks++;
    if (n_drain != 8 || last_drain - first_drain != 7 || n_warm != 0 || n_steady != 0) begin
      errors++;
      $display("FAIL drain_len n %0d span %0d warm %0d steady %0d want 8 8 0 0", n_drain,
               last_drain - first_drain + 1, n_warm, n_steady);
    end
    checks++;
    if (i_ctrl_state !== 4'd0 || timed_out !== 1'b0) begin
      errors++; $display("FAIL drain_idle_after ctrl %0d busy %b want 0 0", i_ctrl_state, timed_out);
    end
  endtask

  task automatic test_st();
    for (int i = 0; i < 4; i++) downmem[i] = 64'hC0DE_0000_0000_0070 + 64'(i);
    load(0, enc(4'd3, 2'd2, 26'h40));
    load(1, enc(4'd1, 2'd0, 26'd0));
    trace(60, 0);
    checks++;
    if (n_drd != 4 || n_mwr != 4 || n_mrd != 0) begin
      errors++; $display("FAIL st_counts rd %0d wr %0d mrd %0d want 4 4 0", n_drd, n_mwr, n_mrd);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (drd_addr[i] !== 4'(i) || mwr_addr[i] !== 26'(32'h40 + i) ||
            mwr_dat[i] !== 64'hC0DE_0000_0000_0070 + 64'(i) || mwr_cyc[i] != drd_cyc[i] + 2) begin
          errors++;
          $display("FAIL st_row%0d rd_addr %0d wr_addr %h data %h dcyc %0d want %0d %h %h 2", i,
                   drd_addr[i], mwr_addr[i], mwr_dat[i], mwr_cyc[i] - drd_cyc[i], i,
                   26'(32'h40 + i), 64'hC0DE_0000_0000_0070 + 64'(i));
        end
      end
    end
  endtask

  task automatic test_nop_halt();
    load(0, enc(4'd0, 2'd0, 26'd0));
    load(1, enc(4'hF, 2'd3, 26'h155));
    load(2, enc(4'd1, 2'd0, 26'd0));
    trace(60, 5);
    checks++;
    if (busy_cycles != 12 || timed_out !== 1'b0) begin
      errors++; $display("FAIL nop_busy_len got %0d stuck %b want 12 0", busy_cycles, timed_out);
    end
    checks++;
    if (n_strobe != 0) begin errors++; $display("FAIL nop_strobes got %0d want 0", n_strobe); end
    trace(60, 0);
    checks++;
    if (n_warm != 0 || busy_cycles != 12) begin
      errors++; $display("FAIL busy_write_ignored warm %0d busy %0d want 0 12", n_warm, busy_cycles);
    end
  endtask

  task automatic test_rst_mid_ld();
    int w;
    logic bad;
    load(0, enc(4'd2, 2'd0, 26'h10));
    load(1, enc(4'd1, 2'd0, 26'd0));
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!mem_rd_en && w < 20) begin tick(); w++; end
    checks++;
    if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL rst_ld_started got %b want 1", mem_rd_en); end
    rst = 1'b1;
    tick();
    checks++;
    if (any_out() !== 1'b0) begin errors++; $display("FAIL rst_mid_ld_outputs got %b want 0", any_out()); end
    tick();
    rst = 1'b0;
    bad = 1'b0;
    repeat (4) begin tick(); if (any_out() !== 1'b0) bad = 1'b1; end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL rst_mid_ld_quiet got %b want 0", bad); end
    trace(60, 0);
    checks++;
    if (n_top != 4 || timed_out !== 1'b0) begin
      errors++; $display("FAIL imem_kept_over_reset wr %0d stuck %b want 4 0", n_top, timed_out);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mainmem[i] = '0;
    for (int i = 0; i < 4; i++) downmem[i] = '0;
    test_reset();
    test_ld_top();
    test_addr_wrap();
    test_ld_left_gemm();
    test_drain();
    test_st();
    test_nop_halt();
    test_rst_mid_ld();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
